// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file family.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_pkg;

    typedef enum logic {
        RF_LAT_COMB = 1'b0,
        RF_LAT_REG  = 1'b1
    } rf_lat_e;

    function automatic int rf_aw(input int n);
        int a;
        a = $clog2(n);
        return (a < 1) ? 1 : a;
    endfunction

endpackage

// File: rtl/register_en_sync_rstn.sv
// Single storage register with load enable and synchronous active-low reset.
// Latency: 1 cycle from en/din to dout.
// Backpressure: none; en=0 holds the stored value.
module register_en_sync_rstn #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] dout_d;
    logic [WIDTH-1:0] dout_q;

    always_comb begin
        dout_d = dout_q;
        if (en) begin
            dout_d = din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_q <= RESET_VAL;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/regfile_mp_sync_rstn.sv
// Multi-port register file: highest write port wins, optional bypass/zero reg/registered read.
// Latency: 0 cycles (READ_LATENCY=0) or 1 cycle (READ_LATENCY=1) read; writes land at the edge.
// Backpressure: none; every enabled access is accepted each cycle.
module regfile_mp_sync_rstn
    import regfile_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter int               N_REG        = 32,
    parameter int               N_RPORTS     = 2,
    parameter int               N_WPORTS     = 1,
    parameter int               READ_LATENCY = 0,
    parameter int               BYPASS       = 1,
    parameter int               ZERO_REG     = 0,
    parameter logic [WIDTH-1:0] RESET_VAL    = '0,
    parameter int               AW           = rf_aw(N_REG)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [N_RPORTS-1:0]                ren,
    input  logic [N_RPORTS-1:0][AW-1:0]        raddr,
    output logic [N_RPORTS-1:0][WIDTH-1:0]     rdata,
    input  logic [N_WPORTS-1:0]                wen,
    input  logic [N_WPORTS-1:0][AW-1:0]        waddr,
    input  logic [N_WPORTS-1:0][WIDTH-1:0]     wdata,
    output logic                               wconflict
);

    logic [N_REG-1:0]                  we;
    logic [N_REG-1:0]                  dup;
    logic [N_REG-1:0][WIDTH-1:0]       wval;
    logic [N_REG-1:0][WIDTH-1:0]       regs;
    logic [N_RPORTS-1:0][WIDTH-1:0]    rsel;
    logic                              wconflict_d;
    logic                              wconflict_q;

    // Ascending port scan: a later (higher-index) hit overwrites, so the top port wins.
    always_comb begin
        we   = '0;
        dup  = '0;
        wval = '0;
        for (int k = 0; k < N_REG; k++) begin
            for (int p = 0; p < N_WPORTS; p++) begin
                if (wen[p] && (int'(waddr[p]) == k)) begin
                    if (we[k]) begin
                        dup[k] = 1'b1;
                    end
                    we[k]   = 1'b1;
                    wval[k] = wdata[p];
                end
            end
        end
        wconflict_d = |dup;
    end

    for (genvar g = 0; g < N_REG; g++) begin : g_reg
        localparam logic [WIDTH-1:0] RV      = ((ZERO_REG != 0) && (g == 0)) ? '0 : RESET_VAL;
        localparam bit               WRITABLE = !((ZERO_REG != 0) && (g == 0));

        register_en_sync_rstn #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RV)
        ) u_reg (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (we[g] && WRITABLE),
            .din   (wval[g]),
            .dout  (regs[g])
        );
    end

    // Read mux by address compare: out-of-range addresses match nothing and yield 0.
    always_comb begin
        for (int j = 0; j < N_RPORTS; j++) begin
            rsel[j] = '0;
            for (int k = 0; k < N_REG; k++) begin
                if ((int'(raddr[j]) == k) && !((ZERO_REG != 0) && (k == 0))) begin
                    rsel[j] = ((BYPASS != 0) && we[k]) ? wval[k] : regs[k];
                end
            end
        end
    end

    if (READ_LATENCY == int'(RF_LAT_REG)) begin : g_rd_reg
        logic [N_RPORTS-1:0][WIDTH-1:0] rdata_d;
        logic [N_RPORTS-1:0][WIDTH-1:0] rdata_q;

        always_comb begin
            for (int j = 0; j < N_RPORTS; j++) begin
                rdata_d[j] = ren[j] ? rsel[j] : rdata_q[j];
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rdata_q <= '0;
            end else begin
                rdata_q <= rdata_d;
            end
        end

        assign rdata = rdata_q;
    end else begin : g_rd_comb
        logic ren_unused;
        assign ren_unused = &{1'b0, ren};
        assign rdata      = rsel;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wconflict_q <= 1'b0;
        end else begin
            wconflict_q <= wconflict_d;
        end
    end

    assign wconflict = wconflict_q;

endmodule

// File: tb/tb_regfile_mp_sync_rstn.sv
// Directed bench over four configurations: bypass comb, read-first comb, registered read, zero reg.
// Latency: n/a. Backpressure: n/a.
// Inputs driven 1 time unit after the rising edge; outputs checked before the next edge.
module tb_regfile_mp_sync_rstn;

    localparam logic [31:0] RV_A = 32'hDEAD_BEEF;
    localparam logic [31:0] RV_D = 32'h5A5A_5A5A;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    logic [1:0]        a_ren, b_ren, c_ren, d_ren;
    logic [1:0][4:0]   a_raddr, b_raddr, c_raddr, d_raddr;
    logic [1:0][31:0]  a_rdata, b_rdata, c_rdata, d_rdata;
    logic [2:0]        a_wen, b_wen, c_wen, d_wen;
    logic [2:0][4:0]   a_waddr, b_waddr, c_waddr, d_waddr;
    logic [2:0][31:0]  a_wdata, b_wdata, c_wdata, d_wdata;
    logic              a_wc, b_wc, c_wc, d_wc;

    regfile_mp_sync_rstn #(.N_REG(32), .N_RPORTS(2), .N_WPORTS(3), .READ_LATENCY(0),
                           .BYPASS(1), .ZERO_REG(0), .RESET_VAL(RV_A)) u_a (
        .clk(clk), .rst_n(rst_n), .ren(a_ren), .raddr(a_raddr), .rdata(a_rdata),
        .wen(a_wen), .waddr(a_waddr), .wdata(a_wdata), .wconflict(a_wc));

    regfile_mp_sync_rstn #(.N_REG(32), .N_RPORTS(2), .N_WPORTS(3), .READ_LATENCY(0),
                           .BYPASS(0), .ZERO_REG(0), .RESET_VAL(32'h0)) u_b (
        .clk(clk), .rst_n(rst_n), .ren(b_ren), .raddr(b_raddr), .rdata(b_rdata),
        .wen(b_wen), .waddr(b_waddr), .wdata(b_wdata), .wconflict(b_wc));

    regfile_mp_sync_rstn #(.N_REG(32), .N_RPORTS(2), .N_WPORTS(3), .READ_LATENCY(1),
                           .BYPASS(1), .ZERO_REG(0), .RESET_VAL(RV_A)) u_c (
        .clk(clk), .rst_n(rst_n), .ren(c_ren), .raddr(c_raddr), .rdata(c_rdata),
        .wen(c_wen), .waddr(c_waddr), .wdata(c_wdata), .wconflict(c_wc));

    regfile_mp_sync_rstn #(.N_REG(24), .N_RPORTS(2), .N_WPORTS(3), .READ_LATENCY(0),
                           .BYPASS(1), .ZERO_REG(1), .RESET_VAL(RV_D)) u_d (
        .clk(clk), .rst_n(rst_n), .ren(d_ren), .raddr(d_raddr), .rdata(d_rdata),
        .wen(d_wen), .waddr(d_waddr), .wdata(d_wdata), .wconflict(d_wc));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        {a_ren, b_ren, c_ren, d_ren} = '0;
        {a_raddr, b_raddr, c_raddr, d_raddr} = '0;
        {a_wen, b_wen, c_wen, d_wen} = '0;
        {a_waddr, b_waddr, c_waddr, d_waddr} = '0;
        {a_wdata, b_wdata, c_wdata, d_wdata} = '0;

        // Reset for two edges with a write pending; the write must be dropped.
        a_wen = 3'b001; a_waddr[0] = 5'd5; a_wdata[0] = 32'h1234;
        c_wen = 3'b001; c_waddr[0] = 5'd5; c_wdata[0] = 32'h1234;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; a_wen = '0; c_wen = '0;
        a_raddr[0] = 5'd5; a_raddr[1] = 5'd31;
        #1;
        chk("a_rst_rd5",  a_rdata[0], RV_A);
        chk("a_rst_rd31", a_rdata[1], RV_A);
        chk("a_rst_wc",   {31'b0, a_wc}, 32'h0);
        chk("c_rst_rdata0", c_rdata[0], 32'h0);
        chk("c_rst_rdata1", c_rdata[1], 32'h0);
        chk("c_rst_wc",   {31'b0, c_wc}, 32'h0);

        // Three-way collision on addr 7: port 2 wins, conflict pulses once.
        a_wen = 3'b111;
        a_waddr[0] = 5'd7; a_waddr[1] = 5'd7; a_waddr[2] = 5'd7;
        a_wdata[0] = 32'd11; a_wdata[1] = 32'd22; a_wdata[2] = 32'd33;
        a_raddr[1] = 5'd7;
        #1;
        chk("a_coll_bypass", a_rdata[1], 32'd33);
        chk("a_coll_wc_pre", {31'b0, a_wc}, 32'h0);
        tick();
        chk("a_coll_wc", {31'b0, a_wc}, 32'h1);
        a_wen = 3'b001; a_waddr[0] = 5'd2; a_wdata[0] = 32'd44;
        a_raddr[0] = 5'd7; a_raddr[1] = 5'd2;
        #1;
        chk("a_coll_stored", a_rdata[0], 32'd33);
        chk("a_byp_addr2",   a_rdata[1], 32'd44);
        tick();
        chk("a_wc_cleared", {31'b0, a_wc}, 32'h0);
        a_wen = '0;
        #1;
        chk("a_addr2_stored", a_rdata[1], 32'd44);

        // Ports 0 and 1 collide on 9, port 2 alone on 10.
        a_wen = 3'b111;
        a_waddr[0] = 5'd9; a_waddr[1] = 5'd9; a_waddr[2] = 5'd10;
        a_wdata[0] = 32'd1; a_wdata[1] = 32'd2; a_wdata[2] = 32'd3;
        tick();
        a_wen = '0; a_raddr[0] = 5'd9; a_raddr[1] = 5'd10;
        #1;
        chk("a_prio_wc", {31'b0, a_wc}, 32'h1);
        chk("a_prio_r9",  a_rdata[0], 32'd2);
        chk("a_prio_r10", a_rdata[1], 32'd3);

        // Write-first comb read, both ports on the same address.
        a_wen = 3'b001; a_waddr[0] = 5'd3; a_wdata[0] = 32'hA5;
        a_raddr[0] = 5'd3; a_raddr[1] = 5'd3;
        #1;
        chk("a_byp_p0", a_rdata[0], 32'hA5);
        chk("a_byp_p1", a_rdata[1], 32'hA5);
        tick();
        a_wen = '0;

        // Read-first comb: old value this cycle, new value after the edge.
        b_wen = 3'b001; b_waddr[0] = 5'd3; b_wdata[0] = 32'hA5; b_raddr[1] = 5'd3;
        #1;
        chk("b_rf_old", b_rdata[1], 32'h0);
        tick();
        b_wen = '0;
        #1;
        chk("b_rf_new", b_rdata[1], 32'hA5);

        // Registered read with enable gating.
        c_wen = 3'b001; c_waddr[0] = 5'd4; c_wdata[0] = 32'h10;
        tick();
        c_wen = '0; c_ren = 2'b01; c_raddr[0] = 5'd4;
        #1;
        chk("c_lat_pre", c_rdata[0], 32'h0);
        tick();
        chk("c_lat_rd",  c_rdata[0], 32'h10);
        chk("c_ren_off", c_rdata[1], 32'h0);
        c_ren = 2'b00; c_wen = 3'b001; c_waddr[0] = 5'd4; c_wdata[0] = 32'h20;
        tick();
        chk("c_hold", c_rdata[0], 32'h10);
        c_ren = 2'b11; c_raddr[1] = 5'd4; c_wdata[0] = 32'h30;
        tick();
        chk("c_byp_p0", c_rdata[0], 32'h30);
        chk("c_byp_p1", c_rdata[1], 32'h30);
        c_wen = '0;

        // Zero register and out-of-range addresses on a 24-entry file.
        d_wen = 3'b011; d_waddr[0] = 5'd0; d_waddr[1] = 5'd30;
        d_wdata[0] = 32'hFF; d_wdata[1] = 32'hFF;
        d_raddr[0] = 5'd0; d_raddr[1] = 5'd30;
        #1;
        chk("d_zero_same", d_rdata[0], 32'h0);
        chk("d_oor_same",  d_rdata[1], 32'h0);
        tick();
        d_wen = '0;
        #1;
        chk("d_wc_distinct", {31'b0, d_wc}, 32'h0);
        chk("d_zero_after",  d_rdata[0], 32'h0);
        chk("d_oor_after",   d_rdata[1], 32'h0);
        d_raddr[0] = 5'd23; d_raddr[1] = 5'd1;
        #1;
        chk("d_r23_untouched", d_rdata[0], RV_D);
        chk("d_r1_untouched",  d_rdata[1], RV_D);
        d_wen = 3'b011; d_waddr[0] = 5'd0; d_waddr[1] = 5'd0;
        tick();
        chk("d_wc_zero_addr", {31'b0, d_wc}, 32'h1);
        d_waddr[0] = 5'd30; d_waddr[1] = 5'd30;
        tick();
        chk("d_wc_oor", {31'b0, d_wc}, 32'h0);
        d_wen = 3'b001; d_waddr[0] = 5'd23; d_wdata[0] = 32'h77;
        tick();
        d_wen = '0; d_raddr[0] = 5'd23; d_raddr[1] = 5'd0;
        #1;
        chk("d_r23_written", d_rdata[0], 32'h77);
        chk("d_r0_still0",   d_rdata[1], 32'h0);

        // Reset in the middle of traffic, coincident with a write to addr 9.
        c_wen = 3'b001; c_waddr[0] = 5'd9; c_wdata[0] = 32'h99;
        c_ren = 2'b11; c_raddr[0] = 5'd9; c_raddr[1] = 5'd4;
        rst_n = 1'b0;
        tick();
        chk("c_mid_rst_rd0", c_rdata[0], 32'h0);
        chk("c_mid_rst_rd1", c_rdata[1], 32'h0);
        rst_n = 1'b1;
        c_waddr[0] = 5'd12; c_wdata[0] = 32'h12;
        tick();
        chk("c_post_rst_r9", c_rdata[0], RV_A);
        chk("c_post_rst_r4", c_rdata[1], RV_A);
        c_wen = '0; c_raddr[1] = 5'd12;
        tick();
        chk("c_post_rst_wr", c_rdata[1], 32'h12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp_sync_rstn.md
Name: regfile_mp_sync_rstn

Overview:
Parametrised multi-port register file with synchronous active-low reset. It is the successor to the single-mode regfile and adds:
- deterministic write-port priority on same-address collisions, with a conflict flag;
- optional registered read ports with per-port read enable;
- optional write-to-read bypass;
- optional hard-wired zero register.

It serves as the architectural register store for CPU/accelerator datapaths in the library.

Parameters:
- WIDTH, 32, bits per register.
- N_REG, 32, number of registers (>=2; need not be a power of two).
- N_RPORTS, 2, number of read ports (>=1).
- N_WPORTS, 1, number of write ports (>=1).
- READ_LATENCY, 0, 0 = combinational read, 1 = registered read.
- BYPASS, 1, 1 = write-first (same-cycle write visible on read), 0 = read-first.
- ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes.
- RESET_VAL, 0, WIDTH-bit value loaded into every register on reset.
- AW, $clog2(N_REG), address width (derived; do not override).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset; sampled on the rising edge of clk.
- ren  in  N_RPORTS  per-port read enable (used only when READ_LATENCY=1).
- raddr  in  N_RPORTS x AW  read addresses.
- rdata  out  N_RPORTS x WIDTH  read data.
- wen  in  N_WPORTS  per-port write enable.
- waddr  in  N_WPORTS x AW  write addresses.
- wdata  in  N_WPORTS x WIDTH  write data.
- wconflict  out  1  registered pulse: two or more enabled write ports targeted the same valid address in the previous cycle.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - all registers load RESET_VAL (register 0 loads 0 when ZERO_REG=1);
  - registered rdata loads 0;
  - wconflict loads 0;
  - all writes in that cycle are ignored.
- Reset mid-operation: a write coincident with reset is dropped. The first edge with rst_n=1 behaves normally.
- Write:
  - register k updates at the edge when any wen[p]=1 with waddr[p]==k;
  - on a multi-port hit, the highest-index port p wins;
  - waddr >= N_REG is ignored;
  - with ZERO_REG=1, writes to address 0 are ignored;
  - unwritten registers hold their value.
- wconflict: 1 in the cycle after any valid address is hit by >=2 enabled ports. This includes address 0 when ZERO_REG=1. It is otherwise 0 and is not sticky.
- Effective write value for address a in a cycle: the data of the winning port if any enabled port targets a, else none.
- Read data selection (priority order):
  - raddr >= N_REG returns 0;
  - address 0 with ZERO_REG=1 returns 0;
  - else, if BYPASS=1 and a same-cycle write targets raddr, returns the winning wdata;
  - else returns the stored register value.
- READ_LATENCY=0:
  - rdata is combinational from the selection above (0-cycle latency);
  - ren is ignored;
  - with BYPASS=0, it shows the pre-write contents.
- READ_LATENCY=1:
  - per port, rdata is registered from the selection at an edge where ren[j]=1;
  - it holds its value when ren[j]=0;
  - latency is 1 cycle;
  - BYPASS=1 captures the value being written that same edge; BYPASS=0 captures the old value.
- Read ports are fully independent. Any number of ports may read the same address.
- No X propagation: out-of-range addresses never index the storage array.

Decomposition:
- Package regfile_pkg:
  - typedef rf_lat_e {RF_LAT_COMB=0, RF_LAT_REG=1};
  - function rf_aw(n) returning max(1,$clog2(n)).
- Sub-module register_en_sync_rstn #(WIDTH, RESET_VAL) (clk, rst_n, en, din, dout) is the per-register storage, instanced N_REG times.
- Write arbitration (highest-port priority encoder per register) and read mux/bypass stay inline.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with RESET_VAL=32'hDEAD_BEEF, wen[0]=1 to addr 5 -> all reads return DEADBEEF, addr 5 unchanged, wconflict=0.
- Collision: N_WPORTS=3; ports 0,1,2 all write addr 7 with 11,22,33 -> reg 7 = 33, wconflict=1 for exactly one cycle; next cycle only port 0 writes -> wconflict=0.
- Bypass comb: READ_LATENCY=0, BYPASS=1; write addr 3 = 0xA5 while raddr[1]=3 -> rdata[1]=0xA5 same cycle. With BYPASS=0 -> old value that cycle, 0xA5 next cycle.
- Registered read: READ_LATENCY=1; ren[0]=1, raddr=4 (holds 0x10) -> rdata[0]=0x10 one cycle later. ren[0]=0 while reg 4 is rewritten to 0x20 -> rdata[0] stays 0x10.
- Zero reg / range: ZERO_REG=1, N_REG=24; write 0xFF to addr 0 and to addr 30 -> reads of 0 and 30 return 0, no register modified.
- Reset mid-stream: random writes/reads, assert rst_n=0 for one edge coincident with a write to addr 9 -> addr 9 = RESET_VAL, registered rdata=0 next cycle.
